// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-stage controller for a 16-bit instruction memory.
// Owns the PC, issues one word read at a time and assembles one- or
// two-word instructions (opcode plus optional immediate). It presents each
// bundle to decode over a valid/ready handshake and applies redirects.
// Optional build macro: FETCH_PERF_CNT_EN enables the accepted-instruction
// counter on fetch_count. Without it, fetch_count is tied to zero.
module fetch_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_AW     = 20,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0020,
  parameter int                    IMM_BIT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_rd,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [15:0]           mem_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_instr,
  output logic [15:0]           out_imm,
  output logic                  out_has_imm,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [31:0]           fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_WORD0    = 3'd2,
    S_ADDR_IMM = 3'd3,
    S_WORD1    = 3'd4,
    S_OUT      = 3'd5
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic                    r_mem_rd;
  logic [MEM_AW-1:0]       r_mem_addr;
  logic                    r_out_valid;
  logic [15:0]             r_out_instr;
  logic [15:0]             r_out_imm;
  logic                    r_out_has_imm;
  logic [ADDR_WIDTH-1:0]   r_out_pc;
  logic [ADDR_WIDTH-1:0]   w_pc_inc;

  // PC increment wraps naturally modulo 2^ADDR_WIDTH.
  assign w_pc_inc = r_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Fetch FSM: the memory strobe, address and out_valid are registered from
  // the state being entered, so each is high exactly while in its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_mem_rd      <= 1'b0;
      r_mem_addr    <= {MEM_AW{1'b0}};
      r_out_valid   <= 1'b0;
      r_out_instr   <= 16'h0000;
      r_out_imm     <= 16'h0000;
      r_out_has_imm <= 1'b0;
      r_out_pc      <= {ADDR_WIDTH{1'b0}};
    end else if (redirect) begin
      // Abandon whatever is in flight; the read data of the old stream is
      // never captured because the FSM restarts from S_ADDR.
      r_state     <= S_ADDR;
      r_pc        <= redirect_pc;
      r_mem_rd    <= 1'b1;
      r_mem_addr  <= redirect_pc[MEM_AW-1:0];
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_ADDR;
          r_mem_rd   <= 1'b1;
          r_mem_addr <= r_pc[MEM_AW-1:0];
        end
        S_ADDR: begin
          r_state  <= S_WORD0;
          r_mem_rd <= 1'b0;
          r_out_pc <= r_pc;
        end
        S_WORD0: begin
          r_out_instr <= mem_data;
          r_pc        <= w_pc_inc;
          if (mem_data[IMM_BIT]) begin
            r_state    <= S_ADDR_IMM;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= w_pc_inc[MEM_AW-1:0];
          end else begin
            r_state       <= S_OUT;
            r_out_imm     <= 16'h0000;
            r_out_has_imm <= 1'b0;
            r_out_valid   <= 1'b1;
          end
        end
        S_ADDR_IMM: begin
          r_state  <= S_WORD1;
          r_mem_rd <= 1'b0;
        end
        S_WORD1: begin
          r_state       <= S_OUT;
          r_out_imm     <= mem_data;
          r_out_has_imm <= 1'b1;
          r_pc          <= w_pc_inc;
          r_out_valid   <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) begin
            r_state     <= S_ADDR;
            r_out_valid <= 1'b0;
            r_mem_rd    <= 1'b1;
            r_mem_addr  <= r_pc[MEM_AW-1:0];
          end else begin
            r_state <= S_OUT;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_mem_rd    <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_mem_addr;
  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_imm     = r_out_imm;
  assign out_has_imm = r_out_has_imm;
  assign out_pc      = r_out_pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic        w_xfer;

  assign w_xfer = r_out_valid & out_ready;

  // Count accepted bundles; a redirect in the same cycle still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= 32'h0000_0000;
    end else if (w_xfer) begin
      r_fetch_count <= r_fetch_count + 32'h0000_0001;
    end else begin
      r_fetch_count <= r_fetch_count;
    end
  end

  assign fetch_count = r_fetch_count;
`else
  assign fetch_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: table-driven program fetch with a bundle
// scoreboard and a read-address scoreboard, plus hand-written redirect,
// reset and PC-wrap sequences.
module tb_fetch_sequencer;

`ifdef FETCH_PERF_CNT_EN
  localparam bit USE_CNT = 1'b1;
`else
  localparam bit USE_CNT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        mem_rd;
  logic [19:0] mem_addr;
  logic [15:0] mem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_imm;
  logic        out_has_imm;
  logic [31:0] out_pc;
  logic [31:0] fetch_count;

  fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_imm     (out_imm),
    .out_has_imm (out_has_imm),
    .out_pc      (out_pc),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] instr;
    logic [15:0] imm;
    logic        has;
  } bundle_t;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    int          hold;
  } vec_t;

  logic [15:0] mem [int unsigned];
  bundle_t     sb_q[$];
  logic [19:0] addr_q[$];
  bundle_t     mon_b;
  logic [19:0] mon_a;
  bit          chk_addr;
  int          n_chk;
  int          n_pass;
  logic [31:0] exp_cnt;

  // Instruction memory model: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd) begin
      if (mem.exists({12'h000, mem_addr})) mem_data <= mem[{12'h000, mem_addr}];
      else                                 mem_data <= 16'h0000;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_count();
    return USE_CNT ? exp_cnt : 32'h0000_0000;
  endfunction

  // Scoreboards: compare accepted bundles and issued read addresses.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        mon_b = sb_q.pop_front();
        chk("out_pc", 64'(out_pc), 64'(mon_b.pc));
        chk("out_instr", 64'(out_instr), 64'(mon_b.instr));
        chk("out_imm", 64'(out_imm), 64'(mon_b.imm));
        chk("out_has_imm", 64'(out_has_imm), 64'(mon_b.has));
      end
    end
    if (chk_addr && mem_rd) begin
      chk("addr_nonempty", 64'(addr_q.size() != 0), 64'd1);
      if (addr_q.size() != 0) begin
        mon_a = addr_q.pop_front();
        chk("mem_addr_seq", 64'(mem_addr), 64'(mon_a));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    chk("wait_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic push_b(input logic [31:0] pc, input logic [15:0] w0, input logic [15:0] w1, input logic has);
    bundle_t b;
    b.pc = pc; b.instr = w0; b.imm = has ? w1 : 16'h0000; b.has = has;
    sb_q.push_back(b);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    exp_cnt = exp_cnt + 32'd1;
    out_ready = 1'b0;
  endtask

  vec_t        tbl [6];
  logic [31:0] pc;
  int          n;
  logic        has;

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    chk_addr = 1'b0; n_chk = 0; n_pass = 0; exp_cnt = 32'h0;

    tbl[0] = '{16'h1234, 16'h0000, 0};
    tbl[1] = '{16'h0005, 16'hBEEF, 10};
    tbl[2] = '{16'h00A0, 16'h0000, 3};
    tbl[3] = '{16'h7FFF, 16'h0001, 0};
    tbl[4] = '{16'hFFFE, 16'h0000, 1};
    tbl[5] = '{16'h0003, 16'h0000, 0};

    // Lay out the table program from 0x20 and queue expectations.
    pc = 32'h20;
    for (int i = 0; i < 6; i++) begin
      has = tbl[i].w0[0];
      mem[pc] = tbl[i].w0;
      push_b(pc, tbl[i].w0, tbl[i].w1, has);
      addr_q.push_back(pc[19:0]);
      pc = pc + 32'd1;
      if (has) begin
        mem[pc] = tbl[i].w1;
        addr_q.push_back(pc[19:0]);
        pc = pc + 32'd1;
      end
    end
    addr_q.push_back(pc[19:0]);
    mem[32'h40] = 16'h0011; mem[32'h41] = 16'h2222;
    mem[32'h100] = 16'h0042; mem[32'h300] = 16'h0ABC;
    mem[32'hFFFFF] = 16'h0101; mem[32'h0] = 16'h5A5A; mem[32'h1] = 16'h0010;

    tick(); tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_count", 64'(fetch_count), 64'd0);

    chk_addr = 1'b1;
    rst = 1'b0;
    tick();
    chk("first_rd", 64'(mem_rd), 64'd1);
    chk("first_addr", 64'(mem_addr), 64'h20);

    for (int i = 0; i < 6; i++) begin
      has = tbl[i].w0[0];
      wait_valid(12, n);
      chk("latency", 64'(n), has ? 64'd4 : 64'd2);
      for (int h = 0; h < tbl[i].hold; h++) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_mem_rd", 64'(mem_rd), 64'd0);
        if (sb_q.size() != 0) begin
          chk("hold_instr", 64'(out_instr), 64'(sb_q[0].instr));
          chk("hold_imm", 64'(out_imm), 64'(sb_q[0].imm));
        end
        tick();
      end
      accept();
      chk("post_xfer_valid", 64'(out_valid), 64'd0);
      chk("count", 64'(fetch_count), 64'(exp_count()));
    end
    tick();
    chk_addr = 1'b0;
    chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
    chk("sb_q_empty", 64'(sb_q.size()), 64'd0);

    // Redirect mid-instruction: the 0x40 two-word fetch is abandoned in S_WORD1.
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk("r1_addr", 64'(mem_addr), 64'h40);
    tick(); tick();
    chk("r1_imm_rd", 64'(mem_rd), 64'd1);
    chk("r1_imm_addr", 64'(mem_addr), 64'h41);
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("r1_drop_valid", 64'(out_valid), 64'd0);
    chk("r1_new_rd", 64'(mem_rd), 64'd1);
    chk("r1_new_addr", 64'(mem_addr), 64'h100);
    push_b(32'h100, 16'h0042, 16'h0000, 1'b0);
    wait_valid(12, n);
    chk("r1_latency", 64'(n), 64'd2);

    // Accepted transfer and redirect in the same cycle.
    redirect = 1'b1; redirect_pc = 32'h300;
    accept();
    redirect = 1'b0;
    chk("r2_valid", 64'(out_valid), 64'd0);
    chk("r2_addr", 64'(mem_addr), 64'h300);
    chk("r2_count", 64'(fetch_count), 64'(exp_count()));
    push_b(32'h300, 16'h0ABC, 16'h0000, 1'b0);
    wait_valid(12, n);

    // Reset while a bundle is being offered.
    rst = 1'b1;
    tick();
    exp_cnt = 32'h0;
    void'(sb_q.pop_front());
    chk("rs_valid", 64'(out_valid), 64'd0);
    chk("rs_mem_rd", 64'(mem_rd), 64'd0);
    chk("rs_addr", 64'(mem_addr), 64'd0);
    chk("rs_instr", 64'(out_instr), 64'd0);
    chk("rs_imm", 64'(out_imm), 64'd0);
    chk("rs_has", 64'(out_has_imm), 64'd0);
    chk("rs_pc", 64'(out_pc), 64'd0);
    chk("rs_count", 64'(fetch_count), 64'd0);

    // Redirect out of S_IDLE to the top of the address space.
    rst = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    chk("wr_addr", 64'(mem_addr), 64'hFFFFF);
    tick(); tick();
    chk("wr_imm_rd", 64'(mem_rd), 64'd1);
    chk("wr_imm_addr", 64'(mem_addr), 64'h0);
    push_b(32'hFFFF_FFFF, 16'h0101, 16'h5A5A, 1'b1);
    wait_valid(12, n);
    chk("wr_latency", 64'(n), 64'd2);
    accept();
    chk("wr_next_rd", 64'(mem_rd), 64'd1);
    chk("wr_next_addr", 64'(mem_addr), 64'h1);
    chk("wr_count", 64'(fetch_count), 64'(exp_count()));

    // Plain reset returns the PC to its reset value.
    rst = 1'b1;
    tick();
    exp_cnt = 32'h0;
    rst = 1'b0;
    tick();
    chk("rp_rd", 64'(mem_rd), 64'd1);
    chk("rp_addr", 64'(mem_addr), 64'h20);
    push_b(32'h20, 16'h1234, 16'h0000, 1'b0);
    wait_valid(12, n);
    accept();
    chk("rp_count", 64'(fetch_count), 64'(exp_count()));
    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
